// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI master controller.
// order_bit() maps a shift position onto a word index for either bit order.
package spi_ctrl_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_NUM_SS = 4;
  localparam int SPI_EDGES  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Bit k of the shift order: k=0 is the first bit on the wire.
  function automatic logic order_bit(input logic [SPI_DATA_W-1:0] word,
                                     input logic [2:0] k,
                                     input logic lsb_first);
    return lsb_first ? word[k] : word[3'd7 - k];
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: emits a one-cycle tick every clk_div+1 enabled cycles.
// The 8-bit counter only wraps on terminal count, so clk_div=255 gives H=256.
module spi_clk_gen (
  input  logic       pclk,
  input  logic       n_p_reset,
  input  logic       enable,
  input  logic [7:0] clk_div,
  output logic       tick
);

  logic [7:0] cnt_reg;

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      cnt_reg <= 8'd0;
    end else if (!enable || (cnt_reg == clk_div)) begin
      cnt_reg <= 8'd0;
    end else begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign tick = enable && (cnt_reg == clk_div);

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-word SPI master: SETUP (H cycles), XFER (16 SCLK edges, H apart),
// HOLD (H cycles), then a one-cycle done pulse with the received word.
module spi_master_ctrl
  import spi_ctrl_pkg::*;
(
  input  logic                  pclk,
  input  logic                  n_p_reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SPI_DATA_W-1:0] tx_data,
  input  logic [1:0]            ss_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [7:0]            clk_div,
  output logic                  busy,
  output logic                  done,
  output logic [SPI_DATA_W-1:0] rx_data,
  input  logic                  mi,
  output logic                  mo,
  output logic                  n_mo_en,
  output logic                  sclk_out,
  output logic                  n_sclk_en,
  output logic [SPI_NUM_SS-1:0] n_ss_out,
  output logic                  n_ss_en
);

  state_t                state_reg, state_next;
  logic [SPI_DATA_W-1:0] tx_lat, rx_sr, rx_data_reg;
  logic [1:0]            ss_lat;
  logic                  cpol_lat, cpha_lat, lsb_lat;
  logic [7:0]            div_lat;
  logic [4:0]            edge_cnt_reg, new_edge;
  logic                  sclk_reg, mo_reg, done_reg;
  logic                  tick, accept, all_edges, active;

  assign active    = (state_reg != ST_IDLE);
  assign accept    = (state_reg == ST_IDLE) && start && !abort;
  assign new_edge  = edge_cnt_reg + 5'd1;
  assign all_edges = (edge_cnt_reg == 5'(SPI_EDGES));

  spi_clk_gen u_clk_gen (
    .pclk      (pclk),
    .n_p_reset (n_p_reset),
    .enable    (active),
    .clk_div   (div_lat),
    .tick      (tick)
  );

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_SETUP;
      ST_SETUP: if (abort) state_next = ST_IDLE;
                else if (tick) state_next = ST_XFER;
      ST_XFER:  if (abort) state_next = ST_IDLE;
                else if (tick && all_edges) state_next = ST_HOLD;
      ST_HOLD:  if (abort || tick) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Edge k (1-based) is leading when odd; the edge that shifts mo is the
  // trailing one for cpha=0 and the leading one for cpha=1.
  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      tx_lat       <= '0;
      ss_lat       <= 2'd0;
      cpol_lat     <= 1'b0;
      cpha_lat     <= 1'b0;
      lsb_lat      <= 1'b0;
      div_lat      <= 8'd0;
      edge_cnt_reg <= 5'd0;
      sclk_reg     <= 1'b0;
      mo_reg       <= 1'b0;
      rx_sr        <= '0;
      rx_data_reg  <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        tx_lat       <= tx_data;
        ss_lat       <= ss_sel;
        cpol_lat     <= cpol;
        cpha_lat     <= cpha;
        lsb_lat      <= lsb_first;
        div_lat      <= clk_div;
        edge_cnt_reg <= 5'd0;
        sclk_reg     <= cpol;
        rx_sr        <= '0;
        mo_reg       <= cpha ? 1'b0 : order_bit(tx_data, 3'd0, lsb_first);
      end else if (!abort && tick) begin
        if ((state_reg == ST_SETUP) || ((state_reg == ST_XFER) && !all_edges)) begin
          sclk_reg     <= ~sclk_reg;
          edge_cnt_reg <= new_edge;
          if (new_edge[0] == cpha_lat) begin
            if (new_edge != 5'(SPI_EDGES))
              mo_reg <= order_bit(tx_lat, new_edge[3:1], lsb_lat);
          end else begin
            rx_sr <= lsb_lat ? {mi, rx_sr[SPI_DATA_W-1:1]}
                             : {rx_sr[SPI_DATA_W-2:0], mi};
          end
        end else if (state_reg == ST_HOLD) begin
          done_reg    <= 1'b1;
          rx_data_reg <= rx_sr;
        end
      end
    end
  end

  always_comb begin
    busy      = active;
    n_ss_en   = ~active;
    n_sclk_en = ~active;
    n_mo_en   = ~active;
    mo        = active & mo_reg;
    sclk_out  = active ? sclk_reg : cpol_lat;
    done      = done_reg;
    rx_data   = rx_data_reg;
  end

  for (genvar gi = 0; gi < SPI_NUM_SS; gi++) begin : g_ss
    assign n_ss_out[gi] = ~(active && (ss_lat == 2'(gi)));
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench: a behavioural SPI slave drives mi and captures mo; a
// monitor pops the expected transfer on every done pulse and compares it.
module tb_spi_master_ctrl;

  logic       pclk = 1'b0;
  logic       n_p_reset = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] ss_sel = 2'd0;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [7:0] clk_div = 8'd0;
  logic       busy, done, mo, n_mo_en, sclk_out, n_sclk_en, n_ss_en;
  logic [7:0] rx_data;
  logic [3:0] n_ss_out;
  logic       mi = 1'b0;

  spi_master_ctrl dut (
    .pclk(pclk), .n_p_reset(n_p_reset), .start(start), .abort(abort),
    .tx_data(tx_data), .ss_sel(ss_sel), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .clk_div(clk_div), .busy(busy), .done(done),
    .rx_data(rx_data), .mi(mi), .mo(mo), .n_mo_en(n_mo_en),
    .sclk_out(sclk_out), .n_sclk_en(n_sclk_en), .n_ss_out(n_ss_out),
    .n_ss_en(n_ss_en)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mi_w;
    logic [1:0] ss;
    logic       cpol, cpha, lsb;
    int         h;
    int         start_cyc;
  } item_t;

  item_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    n_done = 0;
  logic [7:0] last_rx = 8'h00;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit k of the wire order of word w.
  function automatic logic wire_bit(input logic [7:0] w, input int k, input logic lsb);
    logic [7:0] t;
    t = w;
    return lsb ? t[k] : t[7-k];
  endfunction

  // Slave model + scoreboard monitor.
  item_t      cur;
  logic       busy_prev = 1'b0, prev_sclk = 1'b0, bad = 1'b0;
  int         edges = 0, samp = 0, first_edge = 0, last_edge = 0, k = 0;
  logic [7:0] mo_word = 8'h00;
  logic [3:0] exp_ss;
  item_t      got;

  always @(negedge pclk) begin
    if (!n_p_reset) begin
      busy_prev = 1'b0;
      prev_sclk = sclk_out;
    end else begin
      if (busy) begin
        if (!busy_prev) begin
          if (exp_q.size() == 0) begin
            chk("spurious_busy", 32'(busy), 32'd0);
          end else begin
            cur = exp_q[0];
          end
          edges = 0; samp = 0; mo_word = 8'h00; bad = 1'b0;
          mi = cur.cpha ? 1'b0 : wire_bit(cur.mi_w, 0, cur.lsb);
        end else if (sclk_out != prev_sclk) begin
          edges++;
          if (edges == 1) first_edge = cyc;
          last_edge = cyc;
          if (edges[0] != cur.cpha) begin
            if (samp < 8) begin
              if (cur.lsb) mo_word[samp] = mo;
              else         mo_word[7-samp] = mo;
            end
            samp++;
          end else begin
            k = cur.cpha ? (edges - 1) / 2 : edges / 2;
            if (k < 8) mi = wire_bit(cur.mi_w, k, cur.lsb);
          end
        end
        exp_ss = 4'hF;
        exp_ss[cur.ss] = 1'b0;
        if (n_ss_out !== exp_ss || n_ss_en !== 1'b0 || n_sclk_en !== 1'b0 || n_mo_en !== 1'b0)
          bad = 1'b1;
        if (edges == 0 && sclk_out !== cur.cpol) bad = 1'b1;
        if (edges == 0 && cur.cpha && mo !== 1'b0) bad = 1'b1;
      end
      busy_prev = busy;
      prev_sclk = sclk_out;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          got = exp_q.pop_front();
          n_done++;
          $display("xfer %0d: tx=%02h mo_seen=%02h rx=%02h exp_rx=%02h H=%0d cpol=%0b cpha=%0b lsb=%0b ss=%0d latency=%0d",
                   n_done, got.tx, mo_word, rx_data, got.mi_w, got.h, got.cpol, got.cpha,
                   got.lsb, got.ss, cyc - got.start_cyc);
          chk("rx_data", 32'(rx_data), 32'(got.mi_w));
          chk("mo_serial", 32'(mo_word), 32'(got.tx));
          chk("latency", 32'(cyc - got.start_cyc), 32'(18 * got.h + 1));
          chk("edge_count", 32'(edges), 32'd16);
          chk("first_edge", 32'(first_edge - got.start_cyc), 32'(got.h + 1));
          chk("edge_span", 32'(last_edge - first_edge), 32'(15 * got.h));
          chk("ss_en_during_xfer", 32'(bad), 32'd0);
          chk("idle_sclk", 32'(sclk_out), 32'(got.cpol));
          chk("idle_ss", 32'(n_ss_out), 32'hF);
        end
      end
    end
  end

  task automatic tick1();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick1();
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic launch(input logic [7:0] tx, input logic [7:0] mw, input logic [1:0] ss,
                        input logic cp, input logic ph, input logic lsb, input logic [7:0] div,
                        output int sc);
    item_t it;
    tick1();
    tx_data = tx; ss_sel = ss; cpol = cp; cpha = ph; lsb_first = lsb; clk_div = div;
    start = 1'b1;
    sc = cyc;
    it.tx = tx; it.mi_w = mw; it.ss = ss; it.cpol = cp; it.cpha = ph; it.lsb = lsb;
    it.h = int'(div) + 1; it.start_cyc = sc;
    exp_q.push_back(it);
    tick1();
    start = 1'b0;
    // Later input changes must not disturb the latched transfer.
    tx_data = 8'($urandom); ss_sel = 2'($urandom); cpol = 1'($urandom);
    cpha = 1'($urandom); lsb_first = 1'($urandom); clk_div = 8'($urandom);
  endtask

  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] mw, input logic [1:0] ss,
                         input logic cp, input logic ph, input logic lsb, input logic [7:0] div,
                         input bit poke);
    int sc;
    launch(tx, mw, ss, cp, ph, lsb, div, sc);
    if (poke) begin
      start = 1'b1; tx_data = ~tx;
      tick1();
      start = 1'b0;
    end
    wait_idle(18 * 256 + 64);
    tick1();
    chk("busy_after_done", 32'(busy), 32'd0);
    last_rx = mw;
  endtask

  task automatic wait_cycle(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 10000) begin
      tick1();
      n++;
    end
  endtask

  int sc;
  logic [7:0] d;

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", 32'(rx_data), 32'd0);
    chk("rst_sclk", 32'(sclk_out), 32'd0);
    chk("rst_mo", 32'(mo), 32'd0);
    chk("rst_ss", 32'(n_ss_out), 32'hF);
    chk("rst_en", 32'({n_ss_en, n_sclk_en, n_mo_en}), 32'h7);
    repeat (3) tick1();
    n_p_reset = 1'b1;
    tick1();

    // Basic mode-0 transfer and an idle-high LSB-first cpha=1 transfer.
    do_xfer(8'hA5, 8'h3C, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    do_xfer(8'h01, 8'hC6, 2'd1, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0);
    chk("idle_high_sclk", 32'(sclk_out), 32'd1);

    // Start pulse while busy with a different word is ignored.
    do_xfer(8'h5A, 8'h96, 2'd3, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1);

    // Abort after edge 5.
    launch(8'hF0, 8'h0F, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1, sc);
    wait_cycle(sc + 5 * 2 + 1);
    abort = 1'b1;
    tick1();
    abort = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_en", 32'({n_ss_en, n_sclk_en, n_mo_en}), 32'h7);
    chk("abort_ss", 32'(n_ss_out), 32'hF);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rx_kept", 32'(rx_data), 32'(last_rx));
    chk("abort_sclk_idle", 32'(sclk_out), 32'd1);
    repeat (3) tick1();
    chk("abort_no_done", 32'(done), 32'd0);

    // Start and abort together in IDLE.
    start = 1'b1; abort = 1'b1;
    tick1();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    tick1();
    chk("start_abort_busy2", 32'(busy), 32'd0);

    // Asynchronous reset in XFER.
    launch(8'h77, 8'hE1, 2'd1, 1'b1, 1'b0, 1'b1, 8'd1, sc);
    wait_cycle(sc + 4 * 2 + 1);
    #2 n_p_reset = 1'b0;
    #1;
    void'(exp_q.pop_back());
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_rx", 32'(rx_data), 32'd0);
    chk("arst_sclk", 32'(sclk_out), 32'd0);
    chk("arst_mo", 32'(mo), 32'd0);
    chk("arst_ss", 32'(n_ss_out), 32'hF);
    chk("arst_en", 32'({n_ss_en, n_sclk_en, n_mo_en}), 32'h7);
    tick1();
    n_p_reset = 1'b1;
    last_rx = 8'h00;
    tick1();
    do_xfer(8'h3E, 8'h81, 2'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);

    // Largest half-period.
    do_xfer(8'h9C, 8'h4B, 2'd3, 1'b1, 1'b1, 1'b0, 8'd255, 1'b0);

    // Randomised transfers.
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom_range(0, 5));
      do_xfer(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), d, 1'($urandom_range(0, 3) == 0));
    end

    repeat (4) tick1();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have one clock, pclk (rising edge); reset n_p_reset is asynchronous and active-low.
REQ-002 Ports (name  direction  width  meaning), SHALL be exactly:
- pclk  in  1  system clock
- n_p_reset  in  1  async active-low reset
- start  in  1  transfer request, sampled in IDLE
- abort  in  1  terminate current transfer
- tx_data  in  8  word to transmit
- ss_sel  in  2  target slave index 0..3
- cpol  in  1  SCLK idle level
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge
- lsb_first  in  1  bit order
- clk_div  in  8  SCLK half-period H = clk_div+1 pclk cycles
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- rx_data  out  8  last completed received word
- mi  in  1  MISO
- mo  out  1  MOSI
- n_mo_en  out  1  MOSI output enable, active-low
- sclk_out  out  1  SPI clock
- n_sclk_en  out  1  SCLK output enable, active-low
- n_ss_out  out  4  slave selects, active-low one-cold
- n_ss_en  out  1  slave-select output enable, active-low

Function
REQ-003 SHALL implement states IDLE, SETUP, XFER, HOLD.
REQ-004 SHALL move IDLE->SETUP on start=1 and abort=0, latching tx_data, ss_sel, cpol, cpha, lsb_first and clk_div in that cycle; later input changes have no effect until the next start.
REQ-005 SHALL drive the following while in SETUP/XFER/HOLD: n_ss_out[ss_sel]=0, all other n_ss_out bits=1, n_ss_en=0, n_sclk_en=0, n_mo_en=0.
REQ-006 SHALL keep SETUP for H cycles with sclk_out=cpol, then enter XFER.
REQ-007 SHALL produce exactly 16 SCLK edges in XFER, spaced H cycles apart, the first at SETUP exit; HOLD is entered after the 16th edge.
REQ-008 When cpha=0, SHALL drive mo with bit 0 of the shift order from SETUP entry, shift mo on trailing edges 1..7 and sample mi on leading edges.
REQ-009 When cpha=1, SHALL hold mo=0 in SETUP, drive bit k on leading edge k (k=0..7) and sample mi on trailing edges.
REQ-010 Bit order SHALL be MSB-first when lsb_first=0 and LSB-first otherwise; received bits SHALL be assembled in the same order.
REQ-011 SHALL keep HOLD for H cycles with sclk_out=cpol, then enter IDLE.
REQ-012 On HOLD->IDLE, SHALL pulse done for exactly one cycle and update rx_data in that same cycle.
REQ-013 Latency: with start accepted in cycle 0, done SHALL assert in cycle 18H+1.
REQ-014 SHALL ignore start while busy=1.
REQ-015 On abort=1 in any non-IDLE state, SHALL enter IDLE on the next cycle with no done pulse and rx_data unchanged.
REQ-016 In IDLE, abort SHALL take priority over start (the transfer is not started).
REQ-017 In IDLE, SHALL drive n_ss_out=4'hF, n_ss_en=1, n_sclk_en=1, n_mo_en=1, mo=0 and sclk_out=last latched cpol.
REQ-018 clk_div=255 (H=256) SHALL work with no counter overflow; the half-period counter is 8 bits, wrapping only on terminal count.

Reset
REQ-019 On n_p_reset=0, SHALL immediately enter IDLE and force: busy=0, done=0, rx_data=0, mo=0, sclk_out=0, n_mo_en=1, n_sclk_en=1, n_ss_en=1, n_ss_out=4'hF, latched cpol=0.
REQ-020 Reset asserted mid-transfer SHALL abandon the transfer without a done pulse; operation resumes on the first pclk after deassertion.

Structure
REQ-021 Package spi_ctrl_pkg SHALL hold the state enum, SPI_DATA_W=8, SPI_NUM_SS=4 and SPI_EDGES=16.
REQ-022 The half-period counter/edge-tick generator SHALL be a sub-module named spi_clk_gen (inputs: enable, clk_div; output: one-cycle edge tick).

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- clk_div=0, cpol=0, cpha=0, MSB-first, tx=8'hA5, mi returns 8'h3C, ss_sel=2 -> mo serial 10100101; n_ss_out=4'b1011 during transfer; done in cycle 19; rx_data=8'h3C.
- clk_div=3, cpol=1, cpha=1, LSB-first, tx=8'h01 -> sclk_out idle high; 16 edges 4 cycles apart; first mo bit=1 at the first leading edge; done in cycle 73.
- abort in XFER after edge 5 -> IDLE next cycle; all enables=1; n_ss_out=4'hF; no done; rx_data keeps its previous value.
- start pulsed during busy with different tx_data -> ignored; the original word completes unchanged.
- n_p_reset low in XFER -> outputs reach reset values without a pclk edge; no done; next start performs a normal transfer.
- start and abort both high in IDLE -> busy stays 0.
